// File: rtl/dcom_rx_pkg.sv
// -----------------------------------------------------------------------------
// dcom_rx_pkg
// Shared definitions for the DCOM receive data buffer:
//   - Avalon word addresses of the CPU-visible registers
//   - STATUS / CONTROL bit positions
//   - FIFO entry layout (packed data word plus byte count and end markers)
//   - SpaceWire end-of-packet control codes (selected by data bit 0)
// Ports: none (package).
// -----------------------------------------------------------------------------
package dcom_rx_pkg;

   // Register word addresses
   localparam logic [11:0] ADDR_DATA    = 12'd0;
   localparam logic [11:0] ADDR_STATUS  = 12'd1;
   localparam logic [11:0] ADDR_CONTROL = 12'd2;
   localparam logic [11:0] ADDR_PKT_CNT = 12'd3;
   localparam logic [11:0] ADDR_ERR_CNT = 12'd4;

   // STATUS bit positions
   localparam int ST_LEVEL_LSB = 0;
   localparam int ST_COUNT_LSB = 16;
   localparam int ST_EOP       = 20;
   localparam int ST_EEP       = 21;
   localparam int ST_EMPTY     = 22;
   localparam int ST_FULL      = 23;
   localparam int ST_UNDERFLOW = 24;
   localparam int ST_IRQ       = 25;

   // CONTROL bit positions
   localparam int CTL_IRQ_EN  = 0;
   localparam int CTL_FLUSH   = 1;
   localparam int CTL_IRQ_ACK = 2;

   // Control character codes; only bit 0 distinguishes them
   localparam logic [7:0] CODE_EOP = 8'h00;
   localparam logic [7:0] CODE_EEP = 8'h01;

   // One queued word
   typedef struct packed {
      logic [63:0] data;
      logic [3:0]  count;
      logic        eop;
      logic        eep;
   } rx_entry_t;

endpackage

// File: rtl/dcom_rx_word_fifo.sv
// -----------------------------------------------------------------------------
// dcom_rx_word_fifo
// Synchronous FIFO of rx_entry_t words with an in-place tag port that marks
// the most recently pushed entry (the tail) as packet-terminating.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         empties the FIFO; overrides push/pop/tag in the same cycle
//   push          write push_entry at the tail (caller guarantees not full)
//   pop           advance the head (caller guarantees not empty)
//   tag, tag_eep  set eop (and optionally eep) on the tail entry
//   head, tail    oldest and newest stored entries
//   level         number of stored entries (clog2(DEPTH)+1 bits)
//   full, empty   level flags
// -----------------------------------------------------------------------------
module dcom_rx_word_fifo
   import dcom_rx_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  rx_entry_t              push_entry,
   input  logic                   pop,
   input  logic                   tag,
   input  logic                   tag_eep,
   output rx_entry_t              head,
   output rx_entry_t              tail,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   rx_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] tail_ptr;

   // Pointers wrap naturally because DEPTH is a power of two
   assign tail_ptr = wr_ptr - 1'b1;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            level <= level + 1'b1;
         else if (pop && !push)
            level <= level - 1'b1;
      end
   end

   // Storage is not reset; the pointers define what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end else if (tag) begin
         mem[tail_ptr].eop <= 1'b1;
         mem[tail_ptr].eep <= tail.eep | tag_eep;
      end
   end

   assign head  = mem[rd_ptr];
   assign tail  = mem[tail_ptr];
   assign full  = (level == FULL_LVL);
   assign empty = (level == '0);

endmodule

// File: rtl/dcom_rx_data_buffer.sv
// -----------------------------------------------------------------------------
// dcom_rx_data_buffer
// Receive-side DCOM data buffer. Packs SpaceWire codec characters
// little-endian into 64-bit words, queues them in a word FIFO and exposes them
// to the CPU over a 64-bit Avalon-MM slave (one fixed wait state on reads,
// zero on writes). A level interrupt flags completed packets or a fill level.
//
// Optional build macro: DCOM_RX_STATS_EN adds saturating 32-bit EOP/EEP packet
// counters at word addresses 3 and 4; without it those addresses read 0.
//
// Ports:
//   clock_sink_clk, reset_sink_reset      clock, synchronous active-high reset
//   spw_rx_valid/flag/data                codec character in
//   spw_rx_read                           character consumed this cycle
//   avalon_slave_data_buffer_*            CPU register slave
//   rx_interrupt_sender_irq               registered level interrupt
// -----------------------------------------------------------------------------
module dcom_rx_data_buffer
   import dcom_rx_pkg::*;
#(
   parameter int FIFO_DEPTH    = 16,
   parameter int IRQ_THRESHOLD = 8
) (
   input  logic        clock_sink_clk,
   input  logic        reset_sink_reset,
   input  logic        spw_rx_valid,
   input  logic        spw_rx_flag,
   input  logic [7:0]  spw_rx_data,
   output logic        spw_rx_read,
   input  logic [11:0] avalon_slave_data_buffer_address,
   input  logic        avalon_slave_data_buffer_read,
   output logic [63:0] avalon_slave_data_buffer_readdata,
   input  logic        avalon_slave_data_buffer_write,
   input  logic [63:0] avalon_slave_data_buffer_writedata,
   output logic        avalon_slave_data_buffer_waitrequest,
   input  logic [7:0]  avalon_slave_data_buffer_byteenable,
   output logic        rx_interrupt_sender_irq
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LVL_W-1:0] THRESH = LVL_W'(IRQ_THRESHOLD);

   logic clk;
   logic rst;
   assign clk = clock_sink_clk;
   assign rst = reset_sink_reset;

   // Packer state: up to 7 pending bytes; the 8th byte commits directly
   logic [55:0] pk_data;
   logic [2:0]  pk_cnt;

   rx_entry_t        commit_entry;
   rx_entry_t        head;
   rx_entry_t        tail;
   logic [LVL_W-1:0] level;
   logic [LVL_W-1:0] level_next;
   logic             full;
   logic             empty;
   logic             commit_need;
   logic             tag_need;
   logic             tag_ok;
   logic             accept;
   logic             push;
   logic             pop;
   logic             is_eep;

   logic             rd_capture;
   logic             rd_phase;
   logic             rd_pop_ok;
   logic             rd_under;
   logic [63:0]      rd_mux;
   logic [63:0]      status_word;
   logic             underflow;
   logic             irq_en;
   logic             irq_en_next;
   logic             irq_flag;
   logic             irq_flag_next;
   logic             irq_set;
   logic             wr_ctl;
   logic             flush;
   logic             ack;

   assign is_eep = (spw_rx_data[0] == CODE_EEP[0]);

   // An end marker with no pending bytes may only tag the newest word while it
   // is still queued, not already terminated, and not leaving the FIFO now.
   assign tag_ok = !empty && !tail.eop && !(pop && level == LVL_W'(1));

   always_comb begin
      commit_need  = 1'b0;
      tag_need     = 1'b0;
      commit_entry = '0;
      if (spw_rx_valid) begin
         if (!spw_rx_flag) begin
            if (pk_cnt == 3'd7) begin
               commit_need        = 1'b1;
               commit_entry.data  = {spw_rx_data, pk_data};
               commit_entry.count = 4'd8;
            end
         end else if (pk_cnt != 3'd0) begin
            // Any terminated word carries eop; eep additionally marks an error end
            commit_need        = 1'b1;
            commit_entry.data  = {8'h00, pk_data};
            commit_entry.count = {1'b0, pk_cnt};
            commit_entry.eop   = 1'b1;
            commit_entry.eep   = is_eep;
         end else if (tag_ok) begin
            tag_need = 1'b1;
         end else begin
            commit_need      = 1'b1;
            commit_entry.eop = 1'b1;
            commit_entry.eep = is_eep;
         end
      end
   end

   assign accept      = spw_rx_valid && !(commit_need && full);
   assign spw_rx_read = accept;
   assign push        = accept && commit_need;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pk_cnt  <= '0;
         pk_data <= '0;
      end else if (accept) begin
         if (!spw_rx_flag && pk_cnt != 3'd7) begin
            for (int k = 0; k < 7; k++)
               if (pk_cnt == 3'(k)) pk_data[8*k +: 8] <= spw_rx_data;
            pk_cnt <= pk_cnt + 3'd1;
         end else begin
            pk_cnt  <= '0;
            pk_data <= '0;
         end
      end
   end

   dcom_rx_word_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_entry(commit_entry),
      .pop       (pop),
      .tag       (accept && tag_need),
      .tag_eep   (is_eep),
      .head      (head),
      .tail      (tail),
      .level     (level),
      .full      (full),
      .empty     (empty)
   );

   // Read handshake: first cycle stalls and registers the data; the second
   // cycle completes and is the only one that causes side effects.
   assign rd_capture = avalon_slave_data_buffer_read && !rd_phase;
   assign avalon_slave_data_buffer_waitrequest = rd_capture;
   assign pop = rd_phase && rd_pop_ok && !empty;

   assign wr_ctl = avalon_slave_data_buffer_write &&
                   avalon_slave_data_buffer_byteenable[0] &&
                   (avalon_slave_data_buffer_address == ADDR_CONTROL);
   assign flush  = wr_ctl && avalon_slave_data_buffer_writedata[CTL_FLUSH];
   assign ack    = wr_ctl && avalon_slave_data_buffer_writedata[CTL_IRQ_ACK];

`ifdef DCOM_RX_STATS_EN
   logic [31:0] pkt_cnt;
   logic [31:0] err_cnt;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pkt_cnt <= '0;
         err_cnt <= '0;
      end else if (accept && spw_rx_flag) begin
         if (!is_eep && pkt_cnt != 32'hFFFF_FFFF) pkt_cnt <= pkt_cnt + 32'd1;
         if (is_eep && err_cnt != 32'hFFFF_FFFF)  err_cnt <= err_cnt + 32'd1;
      end
   end
`endif

   always_comb begin
      status_word = '0;
      status_word[ST_LEVEL_LSB +: 16] = 16'(level);
      if (!empty) begin
         status_word[ST_COUNT_LSB +: 4] = head.count;
         status_word[ST_EOP]            = head.eop;
         status_word[ST_EEP]            = head.eep;
      end
      status_word[ST_EMPTY]     = empty;
      status_word[ST_FULL]      = full;
      status_word[ST_UNDERFLOW] = underflow;
      status_word[ST_IRQ]       = irq_flag;
   end

   always_comb begin
      rd_mux = '0;
      case (avalon_slave_data_buffer_address)
         ADDR_DATA:    rd_mux = empty ? 64'd0 : head.data;
         ADDR_STATUS:  rd_mux = status_word;
         ADDR_CONTROL: rd_mux = {63'd0, irq_en};
`ifdef DCOM_RX_STATS_EN
         ADDR_PKT_CNT: rd_mux = {32'd0, pkt_cnt};
         ADDR_ERR_CNT: rd_mux = {32'd0, err_cnt};
`endif
         default:      rd_mux = '0;
      endcase
   end

   always_comb begin
      level_next = level;
      if (push && !pop)
         level_next = level + 1'b1;
      else if (pop && !push)
         level_next = level - 1'b1;
   end

   // A flush cancels the same-cycle commit, so it also cancels its irq event
   assign irq_set = !flush &&
                    ((push && commit_entry.eop) ||
                     (accept && tag_need) ||
                     (level < THRESH && level_next >= THRESH));

   assign irq_flag_next = irq_set ? 1'b1 : (ack ? 1'b0 : irq_flag);
   assign irq_en_next   = wr_ctl ? avalon_slave_data_buffer_writedata[CTL_IRQ_EN] : irq_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_phase                          <= 1'b0;
         rd_pop_ok                         <= 1'b0;
         rd_under                          <= 1'b0;
         underflow                         <= 1'b0;
         irq_en                            <= 1'b0;
         irq_flag                          <= 1'b0;
         rx_interrupt_sender_irq           <= 1'b0;
         avalon_slave_data_buffer_readdata <= '0;
      end else begin
         rd_phase <= rd_capture;
         if (rd_capture) begin
            avalon_slave_data_buffer_readdata <= rd_mux;
            // Decide pop/underflow from the state the returned data reflects
            rd_pop_ok <= (avalon_slave_data_buffer_address == ADDR_DATA) && !empty;
            rd_under  <= (avalon_slave_data_buffer_address == ADDR_DATA) && empty;
         end
         if (flush)
            underflow <= 1'b0;
         else if (rd_phase && rd_under)
            underflow <= 1'b1;
         irq_en                  <= irq_en_next;
         irq_flag                <= irq_flag_next;
         rx_interrupt_sender_irq <= irq_flag_next && irq_en_next;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{avalon_slave_data_buffer_byteenable[7:1],
                          avalon_slave_data_buffer_writedata[63:3],
                          tail.data, tail.count, avalon_slave_data_buffer_write};

endmodule
